// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I core: byte-serial loads/stores over the 8-bit memory controller port.
// Optional MEM_MISALIGN_ERR_EN rejects misaligned halfword/word accesses and adds misalign_err_o.
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CMD_W  = 6
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              valid_in,
   input  logic [CMD_W-1:0]  cmdtype_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [DATA_W-1:0] store_val_in,
   input  logic [4:0]        rsd_addr_in,
   input  logic [DATA_W-1:0] rsd_data_in,
   input  logic              write_rsd_in,
   output logic              mc_req_o,
   output logic              mc_we_o,
   output logic [ADDR_W-1:0] mc_addr_o,
   output logic [7:0]        mc_wdata_o,
   input  logic              mc_ack_i,
   input  logic [7:0]        mc_rdata_i,
   output logic              stall_mem_o,
   output logic              wb_write_o,
   output logic [4:0]        wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              mem_forward_id_o,
   output logic [4:0]        mem_forward_addr_o,
   output logic [DATA_W-1:0] mem_forward_data_o,
   output logic              isloading_mem_o
`ifdef MEM_MISALIGN_ERR_EN
   ,
   output logic              misalign_err_o
`endif
);

   // Memory command codes shared with the decoder; all other codes are non-memory ops.
   localparam logic [CMD_W-1:0] CMD_LB  = CMD_W'(11);
   localparam logic [CMD_W-1:0] CMD_LH  = CMD_W'(12);
   localparam logic [CMD_W-1:0] CMD_LW  = CMD_W'(13);
   localparam logic [CMD_W-1:0] CMD_LBU = CMD_W'(14);
   localparam logic [CMD_W-1:0] CMD_LHU = CMD_W'(15);
   localparam logic [CMD_W-1:0] CMD_SB  = CMD_W'(16);
   localparam logic [CMD_W-1:0] CMD_SH  = CMD_W'(17);
   localparam logic [CMD_W-1:0] CMD_SW  = CMD_W'(18);

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_t;

   function automatic logic f_is_load(input logic [CMD_W-1:0] c);
      return (c == CMD_LB) || (c == CMD_LH) || (c == CMD_LW) ||
             (c == CMD_LBU) || (c == CMD_LHU);
   endfunction

   function automatic logic f_is_store(input logic [CMD_W-1:0] c);
      return (c == CMD_SB) || (c == CMD_SH) || (c == CMD_SW);
   endfunction

   // Index of the final byte: N-1 for an N-byte access.
   function automatic logic [1:0] f_last_idx(input logic [CMD_W-1:0] c);
      if ((c == CMD_LW) || (c == CMD_SW))
         return 2'd3;
      else if ((c == CMD_LH) || (c == CMD_LHU) || (c == CMD_SH))
         return 2'd1;
      else
         return 2'd0;
   endfunction

   function automatic logic [DATA_W-1:0] f_extend(input logic [CMD_W-1:0] c,
                                                  input logic [31:0]      raw);
      if (c == CMD_LB)
         return {{(DATA_W-8){raw[7]}}, raw[7:0]};
      else if (c == CMD_LBU)
         return {{(DATA_W-8){1'b0}}, raw[7:0]};
      else if (c == CMD_LH)
         return {{(DATA_W-16){raw[15]}}, raw[15:0]};
      else if (c == CMD_LHU)
         return {{(DATA_W-16){1'b0}}, raw[15:0]};
      else
         return DATA_W'(raw);
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CMD_W-1:0]    r_op;
   logic                r_is_load;
   logic                r_is_store;
   logic [1:0]          r_last_idx;
   logic [1:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_store;
   logic [4:0]          r_rd;
   logic                r_write_rsd;
   logic [31:0]         r_data;
   logic                r_wb_write;
   logic [4:0]          r_wb_addr;
   logic [DATA_W-1:0]   r_wb_data;

   logic                w_access;
   logic                w_in_mem;
   logic                w_in_load;
   logic                w_misalign;
   logic                w_accept_mem;
   logic                w_last_ack;
   logic [4:0]          w_bit_sel;
   logic [31:0]         w_raw;
   logic [DATA_W-1:0]   w_load_val;

   assign w_access  = (r_state == ST_ACCESS);
   assign w_in_load = f_is_load(cmdtype_in);
   assign w_in_mem  = w_in_load | f_is_store(cmdtype_in);
   assign w_bit_sel = {r_cnt, 3'b000};

`ifdef MEM_MISALIGN_ERR_EN
   assign w_misalign =
      (((cmdtype_in == CMD_LH) || (cmdtype_in == CMD_LHU) || (cmdtype_in == CMD_SH)) &&
       mem_addr_in[0]) ||
      (((cmdtype_in == CMD_LW) || (cmdtype_in == CMD_SW)) && (mem_addr_in[1:0] != 2'b00));
   assign misalign_err_o = ~w_access & valid_in & w_in_mem & w_misalign;
`else
   assign w_misalign = 1'b0;
`endif

   assign w_accept_mem = ~w_access & valid_in & w_in_mem & ~w_misalign;
   // An ack only counts while a byte is actually being requested.
   assign w_last_ack   = w_access & mc_ack_i & (r_cnt == r_last_idx);

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_raw = r_data;
      w_raw[w_bit_sel +: 8] = mc_rdata_i;
   end

   assign w_load_val = f_extend(r_op, w_raw);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_accept_mem) w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (w_last_ack)   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_op        <= '0;
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_last_idx  <= '0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_store     <= '0;
         r_rd        <= '0;
         r_write_rsd <= 1'b0;
         r_data      <= '0;
      end else if (w_accept_mem) begin
         r_op        <= cmdtype_in;
         r_is_load   <= w_in_load;
         r_is_store  <= ~w_in_load;
         r_last_idx  <= f_last_idx(cmdtype_in);
         r_cnt       <= '0;
         r_addr      <= mem_addr_in;
         r_store     <= store_val_in;
         r_rd        <= rsd_addr_in;
         r_write_rsd <= write_rsd_in;
      end else if (w_access && mc_ack_i) begin
         if (r_is_load)
            r_data[w_bit_sel +: 8] <= mc_rdata_i;
         r_cnt <= r_cnt + 2'd1;
      end
   end

   // MEM/WB latch: ALU results pass straight through, loads land on the last ack.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wb_write <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else if (w_last_ack) begin
         r_wb_write <= r_is_load & r_write_rsd;
         if (r_is_load) begin
            r_wb_addr <= r_rd;
            r_wb_data <= w_load_val;
         end
      end else if (!w_access && valid_in && !w_in_mem) begin
         r_wb_write <= write_rsd_in;
         r_wb_addr  <= rsd_addr_in;
         r_wb_data  <= rsd_data_in;
      end else begin
         r_wb_write <= 1'b0;
      end
   end

   assign wb_write_o = r_wb_write;
   assign wb_addr_o  = r_wb_addr;
   assign wb_data_o  = r_wb_data;

   assign mc_req_o   = w_access;
   assign mc_we_o    = w_access & r_is_store;
   assign mc_addr_o  = w_access ? (r_addr + ADDR_W'(r_cnt)) : '0;
   assign mc_wdata_o = (w_access && r_is_store) ? r_store[w_bit_sel +: 8] : 8'h00;

   assign stall_mem_o     = w_accept_mem | (w_access & ~w_last_ack);
   assign isloading_mem_o = (w_accept_mem & w_in_load) | (w_access & r_is_load & ~w_last_ack);

   always_comb begin
      mem_forward_id_o   = 1'b0;
      mem_forward_addr_o = '0;
      mem_forward_data_o = '0;
      if (!w_access && valid_in && !w_in_load && write_rsd_in) begin
         mem_forward_id_o   = 1'b1;
         mem_forward_addr_o = rsd_addr_in;
         mem_forward_data_o = rsd_data_in;
      end else if (w_last_ack && r_is_load) begin
         mem_forward_id_o   = r_write_rsd;
         mem_forward_addr_o = r_rd;
         mem_forward_data_o = w_load_val;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte-addressed memory responder with configurable ack latency
// and a word-level reference model of loads, stores, forwarding and stalls.
module tb_mem_access_stage;

   localparam logic [5:0] CMD_LB  = 6'd11;
   localparam logic [5:0] CMD_LH  = 6'd12;
   localparam logic [5:0] CMD_LW  = 6'd13;
   localparam logic [5:0] CMD_LBU = 6'd14;
   localparam logic [5:0] CMD_LHU = 6'd15;
   localparam logic [5:0] CMD_SB  = 6'd16;
   localparam logic [5:0] CMD_SH  = 6'd17;
   localparam logic [5:0] CMD_SW  = 6'd18;
   localparam logic [5:0] CMD_ADD = 6'd1;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        valid_in;
   logic [5:0]  cmdtype_in;
   logic [31:0] mem_addr_in;
   logic [31:0] store_val_in;
   logic [4:0]  rsd_addr_in;
   logic [31:0] rsd_data_in;
   logic        write_rsd_in;
   logic        mc_req_o;
   logic        mc_we_o;
   logic [31:0] mc_addr_o;
   logic [7:0]  mc_wdata_o;
   logic        mc_ack_i;
   logic [7:0]  mc_rdata_i;
   logic        stall_mem_o;
   logic        wb_write_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic        mem_forward_id_o;
   logic [4:0]  mem_forward_addr_o;
   logic [31:0] mem_forward_data_o;
   logic        isloading_mem_o;
`ifdef MEM_MISALIGN_ERR_EN
   logic        misalign_err_o;
`endif

   mem_access_stage dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .valid_in           (valid_in),
      .cmdtype_in         (cmdtype_in),
      .mem_addr_in        (mem_addr_in),
      .store_val_in       (store_val_in),
      .rsd_addr_in        (rsd_addr_in),
      .rsd_data_in        (rsd_data_in),
      .write_rsd_in       (write_rsd_in),
      .mc_req_o           (mc_req_o),
      .mc_we_o            (mc_we_o),
      .mc_addr_o          (mc_addr_o),
      .mc_wdata_o         (mc_wdata_o),
      .mc_ack_i           (mc_ack_i),
      .mc_rdata_i         (mc_rdata_i),
      .stall_mem_o        (stall_mem_o),
      .wb_write_o         (wb_write_o),
      .wb_addr_o          (wb_addr_o),
      .wb_data_o          (wb_data_o),
      .mem_forward_id_o   (mem_forward_id_o),
      .mem_forward_addr_o (mem_forward_addr_o),
      .mem_forward_data_o (mem_forward_data_o),
      .isloading_mem_o    (isloading_mem_o)
`ifdef MEM_MISALIGN_ERR_EN
      ,
      .misalign_err_o     (misalign_err_o)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } xfer_t;

   xfer_t       log_q[$];
   logic [7:0]  mem [logic [31:0]];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ack_delay = 0;
   bit          spurious  = 1'b0;
   bit          pending   = 1'b0;
   int          waited    = 0;
   logic [31:0] p_addr;
   logic        p_we;
   logic [7:0]  p_wdata;

   function automatic bit is_load(input logic [5:0] c);
      return c inside {CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU};
   endfunction

   function automatic bit is_store(input logic [5:0] c);
      return c inside {CMD_SB, CMD_SH, CMD_SW};
   endfunction

   function automatic int nbytes(input logic [5:0] c);
      if (c inside {CMD_LW, CMD_SW}) return 4;
      if (c inside {CMD_LH, CMD_LHU, CMD_SH}) return 2;
      return 1;
   endfunction

   // Architectural load result from the byte memory, using signed integer arithmetic.
   function automatic logic [31:0] ref_load(input logic [5:0] c, input logic [31:0] a);
      longint v;
      longint b0;
      longint h;
      b0 = longint'(mem[a]);
      v  = b0;
      if (c inside {CMD_LH, CMD_LHU, CMD_LW}) begin
         h = b0 + 256 * longint'(mem[a + 32'd1]);
         v = h;
         if (c == CMD_LH && h >= 32768) v = h - 65536;
         if (c == CMD_LW)
            v = h + 65536 * longint'(mem[a + 32'd2]) + 16777216 * longint'(mem[a + 32'd3]);
      end
      if (c == CMD_LB && b0 >= 128) v = b0 - 256;
      return 32'(v);
   endfunction

   // Memory controller model: acks each requested byte after ack_delay waiting cycles.
   always @(negedge clk_in) begin
      if (!rst_in || !mc_req_o) begin
         pending    = 1'b0;
         mc_ack_i   = rst_in ? spurious : 1'b0;
         mc_rdata_i = 8'($urandom);
      end else begin
         if (mc_ack_i) pending = 1'b0;
         mc_ack_i = 1'b0;
         if (!pending) begin
            pending = 1'b1;
            waited  = 0;
            p_addr  = mc_addr_o;
            p_we    = mc_we_o;
            p_wdata = mc_wdata_o;
         end else begin
            n_checks++;
            if ({mc_addr_o, mc_we_o, mc_wdata_o} !== {p_addr, p_we, p_wdata}) begin
               n_fail++;
               $display("FAIL req_stable: got %h/%b/%h exp %h/%b/%h",
                        mc_addr_o, mc_we_o, mc_wdata_o, p_addr, p_we, p_wdata);
            end
         end
         if (waited >= ack_delay) begin
            mc_ack_i = 1'b1;
            if (p_we) begin
               mem[p_addr] = p_wdata;
               mc_rdata_i  = 8'($urandom);
            end else begin
               if (!mem.exists(p_addr)) mem[p_addr] = 8'($urandom);
               mc_rdata_i = mem[p_addr];
            end
            log_q.push_back('{addr: p_addr, we: p_we, wdata: p_wdata});
         end else begin
            waited++;
         end
      end
   end

   // One EX/MEM entry held until the stage releases it, checked against the reference model.
   task automatic run_op(input logic [5:0] cmd, input logic [31:0] addr, input logic [31:0] sval,
                         input logic [4:0] rd, input logic [31:0] rdat, input logic wr,
                         input string tag);
      bit          ld;
      bit          st;
      int          n;
      int          stalls;
      bit          done;
      bit          isl_ok;
      logic        exp_w;
      logic [31:0] exp_val;
      ld = is_load(cmd);
      st = is_store(cmd);
      n  = nbytes(cmd);
      exp_val = rdat;
      if (ld) begin
         for (int i = 0; i < n; i++)
            if (!mem.exists(addr + 32'(i))) mem[addr + 32'(i)] = 8'($urandom);
         exp_val = ref_load(cmd, addr);
      end
      log_q.delete();
      @(negedge clk_in);
      valid_in = 1'b1; cmdtype_in = cmd; mem_addr_in = addr; store_val_in = sval;
      rsd_addr_in = rd; rsd_data_in = rdat; write_rsd_in = wr;
      #1;
      n_checks++;
      if (stall_mem_o !== (ld || st)) begin
         n_fail++; $display("FAIL %s accept_stall: got %b exp %b", tag, stall_mem_o, ld || st);
      end
      n_checks++;
      if (isloading_mem_o !== ld) begin
         n_fail++; $display("FAIL %s accept_isloading: got %b exp %b", tag, isloading_mem_o, ld);
      end
      n_checks++;
      if (mem_forward_id_o !== (!ld && wr)) begin
         n_fail++; $display("FAIL %s accept_fwd: got %b exp %b", tag, mem_forward_id_o, !ld && wr);
      end
      if (!ld && wr) begin
         n_checks++;
         if ({mem_forward_addr_o, mem_forward_data_o} !== {rd, rdat}) begin
            n_fail++; $display("FAIL %s fwd_value: got %0d/%h exp %0d/%h", tag,
                               mem_forward_addr_o, mem_forward_data_o, rd, rdat);
         end
      end
      if (ld || st) begin
         stalls = 1; done = 1'b0; isl_ok = 1'b1;
         for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk_in); #1;
            if (stall_mem_o) begin
               stalls++;
               if (isloading_mem_o !== ld) isl_ok = 1'b0;
            end else begin
               done = 1'b1;
            end
         end
         n_checks++;
         if (!done) begin
            n_fail++; $display("FAIL %s access_timeout: got stalled exp release within 400", tag);
         end
         n_checks++;
         if (stalls != n * (ack_delay + 1)) begin
            n_fail++; $display("FAIL %s stall_cycles: got %0d exp %0d", tag, stalls, n * (ack_delay + 1));
         end
         n_checks++;
         if (!isl_ok) begin
            n_fail++; $display("FAIL %s isloading_access: got wrong exp %b", tag, ld);
         end
         n_checks++;
         if (isloading_mem_o !== 1'b0) begin
            n_fail++; $display("FAIL %s isloading_last: got %b exp 0", tag, isloading_mem_o);
         end
         n_checks++;
         if ({mem_forward_id_o, mem_forward_addr_o, mem_forward_data_o} !==
             (ld ? {1'b1, rd, exp_val} : 38'd0)) begin
            n_fail++; $display("FAIL %s last_fwd: got %b/%0d/%h exp %b/%0d/%h", tag, mem_forward_id_o,
                               mem_forward_addr_o, mem_forward_data_o, ld, rd, exp_val);
         end
      end
      @(negedge clk_in);
      valid_in = 1'b0;
      #1;
      exp_w = st ? 1'b0 : wr;
      n_checks++;
      if (wb_write_o !== exp_w) begin
         n_fail++; $display("FAIL %s wb_write: got %b exp %b", tag, wb_write_o, exp_w);
      end
      if (exp_w) begin
         n_checks++;
         if ({wb_addr_o, wb_data_o} !== {rd, exp_val}) begin
            n_fail++; $display("FAIL %s wb_value: got %0d/%h exp %0d/%h", tag, wb_addr_o, wb_data_o,
                               rd, exp_val);
         end
      end
      n_checks++;
      if (log_q.size() != ((ld || st) ? n : 0)) begin
         n_fail++; $display("FAIL %s byte_count: got %0d exp %0d", tag, log_q.size(), (ld || st) ? n : 0);
      end
      for (int i = 0; i < log_q.size() && i < n; i++) begin
         n_checks++;
         if (log_q[i].addr !== addr + 32'(i) || log_q[i].we !== st ||
             (st && log_q[i].wdata !== 8'(sval >> (8 * i)))) begin
            n_fail++; $display("FAIL %s byte%0d: got %h/%b/%h exp %h/%b/%h", tag, i, log_q[i].addr,
                               log_q[i].we, log_q[i].wdata, addr + 32'(i), st, 8'(sval >> (8 * i)));
         end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0; valid_in = 1'b0; cmdtype_in = '0; mem_addr_in = '0; store_val_in = '0;
      rsd_addr_in = '0; rsd_data_in = '0; write_rsd_in = 1'b0;
      repeat (3) @(negedge clk_in);
      #1;
      n_checks++;
      if ({mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o, stall_mem_o, wb_write_o, wb_addr_o, wb_data_o,
           mem_forward_id_o, mem_forward_addr_o, mem_forward_data_o, isloading_mem_o} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got nonzero exp all zero");
      end
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic test_lw_directed();
      ack_delay = 0;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      run_op(CMD_LW, 32'h100, 32'h0, 5'd3, 32'h0, 1'b1, "lw_directed");
      n_checks++;
      if (wb_data_o !== 32'h12345678) begin
         n_fail++; $display("FAIL lw_const: got %h exp 12345678", wb_data_o);
      end
   endtask

   task automatic test_extend();
      ack_delay = 1;
      mem[32'h40] = 8'h80; mem[32'h50] = 8'h00; mem[32'h51] = 8'h80;
      run_op(CMD_LB, 32'h40, 32'h0, 5'd4, 32'h0, 1'b1, "lb");
      n_checks++;
      if (wb_data_o !== 32'hFFFFFF80) begin
         n_fail++; $display("FAIL lb_const: got %h exp ffffff80", wb_data_o);
      end
      run_op(CMD_LBU, 32'h40, 32'h0, 5'd4, 32'h0, 1'b1, "lbu");
      n_checks++;
      if (wb_data_o !== 32'h00000080) begin
         n_fail++; $display("FAIL lbu_const: got %h exp 00000080", wb_data_o);
      end
      run_op(CMD_LH, 32'h50, 32'h0, 5'd6, 32'h0, 1'b1, "lh");
      n_checks++;
      if (wb_data_o !== 32'hFFFF8000) begin
         n_fail++; $display("FAIL lh_const: got %h exp ffff8000", wb_data_o);
      end
   endtask

   task automatic test_sh_delayed();
      ack_delay = 3;
      run_op(CMD_SH, 32'h202, 32'hABCD1234, 5'd0, 32'h0, 1'b0, "sh_delayed");
      n_checks++;
      if (log_q.size() != 2 || log_q[0].addr !== 32'h202 || log_q[0].wdata !== 8'h34 ||
          log_q[1].addr !== 32'h203 || log_q[1].wdata !== 8'h12) begin
         n_fail++; $display("FAIL sh_const: got %0d bytes exp (202,34),(203,12)", log_q.size());
      end
   endtask

   task automatic test_alu();
      run_op(CMD_ADD, 32'h0, 32'h0, 5'd5, 32'd7, 1'b1, "add_rd5");
      run_op(CMD_ADD, 32'h0, 32'h0, 5'd0, 32'h55, 1'b1, "add_x0");
      run_op(CMD_ADD, 32'h0, 32'h0, 5'd9, 32'h77, 1'b0, "add_nowrite");
      @(negedge clk_in); #1;
      n_checks++;
      if (wb_write_o !== 1'b0 || mem_forward_id_o !== 1'b0) begin
         n_fail++; $display("FAIL bubble: got wb %b fwd %b exp 0 0", wb_write_o, mem_forward_id_o);
      end
   endtask

   task automatic test_spurious_ack();
      spurious = 1'b1;
      log_q.delete();
      repeat (3) @(negedge clk_in);
      #1;
      n_checks++;
      if (mc_req_o !== 1'b0 || stall_mem_o !== 1'b0 || wb_write_o !== 1'b0 || log_q.size() != 0) begin
         n_fail++; $display("FAIL spurious_ack: got req %b stall %b wb %b exp 0 0 0",
                            mc_req_o, stall_mem_o, wb_write_o);
      end
      spurious = 1'b0;
      ack_delay = 0;
      run_op(CMD_LBU, 32'h77, 32'h0, 5'd8, 32'h0, 1'b1, "after_spurious");
   endtask

   task automatic test_reset_mid_access();
      bit reached;
      ack_delay = 0;
      reached = 1'b0;
      log_q.delete();
      @(negedge clk_in);
      valid_in = 1'b1; cmdtype_in = CMD_LW; mem_addr_in = 32'h300; rsd_addr_in = 5'd7; write_rsd_in = 1'b1;
      for (int c = 0; c < 50 && !reached; c++) begin
         @(negedge clk_in); #1;
         if (log_q.size() >= 2) reached = 1'b1;
      end
      n_checks++;
      if (!reached) begin
         n_fail++; $display("FAIL rst_mid_progress: got %0d acks exp 2", log_q.size());
      end
      @(posedge clk_in); #1;
      rst_in = 1'b0; valid_in = 1'b0;
      #1;
      n_checks++;
      if (mc_req_o !== 1'b0 || wb_write_o !== 1'b0 || stall_mem_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_abort: got req %b wb %b stall %b exp 0 0 0",
                            mc_req_o, wb_write_o, stall_mem_o);
      end
      @(negedge clk_in);
      rst_in = 1'b1;
      run_op(CMD_SB, 32'h310, 32'h000000A5, 5'd0, 32'h0, 1'b0, "sb_after_reset");
   endtask

`ifndef MEM_MISALIGN_ERR_EN
   task automatic test_wrap();
      ack_delay = 0;
      run_op(CMD_LW, 32'hFFFFFFFE, 32'h0, 5'd11, 32'h0, 1'b1, "lw_wrap");
      run_op(CMD_SH, 32'hFFFFFFFF, 32'h0000BEEF, 5'd0, 32'h0, 1'b0, "sh_wrap");
   endtask
`else
   task automatic test_misalign();
      log_q.delete();
      @(negedge clk_in);
      valid_in = 1'b1; cmdtype_in = CMD_LW; mem_addr_in = 32'h101; rsd_addr_in = 5'd2; write_rsd_in = 1'b1;
      #1;
      n_checks++;
      if (misalign_err_o !== 1'b1 || stall_mem_o !== 1'b0 || isloading_mem_o !== 1'b0) begin
         n_fail++; $display("FAIL misalign_accept: got err %b stall %b isl %b exp 1 0 0",
                            misalign_err_o, stall_mem_o, isloading_mem_o);
      end
      @(negedge clk_in);
      valid_in = 1'b0;
      #1;
      n_checks++;
      if (misalign_err_o !== 1'b0 || mc_req_o !== 1'b0 || wb_write_o !== 1'b0 || log_q.size() != 0) begin
         n_fail++; $display("FAIL misalign_after: got err %b req %b wb %b bytes %0d exp 0 0 0 0",
                            misalign_err_o, mc_req_o, wb_write_o, log_q.size());
      end
   endtask
`endif

   task automatic test_random();
      logic [5:0]  kinds [9];
      logic [5:0]  cmd;
      logic [31:0] addr;
      kinds = '{CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU, CMD_SB, CMD_SH, CMD_SW, CMD_ADD};
      for (int i = 0; i < 60; i++) begin
         cmd = kinds[$urandom_range(0, 8)];
         if (cmd == CMD_ADD) cmd = 6'($urandom_range(0, 10));
         addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                            : 32'h1000 + 32'($urandom_range(0, 31));
`ifdef MEM_MISALIGN_ERR_EN
         addr = addr & ~32'(nbytes(cmd) - 1);
`endif
         ack_delay = $urandom_range(0, 2);
         run_op(cmd, addr, $urandom, 5'($urandom), $urandom,
                is_load(cmd) ? 1'b1 : (is_store(cmd) ? 1'b0 : 1'($urandom)), "random");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "simulation timeout");
   end

   initial begin
      mc_ack_i = 1'b0;
      mc_rdata_i = 8'h00;
      test_reset();
      test_lw_directed();
      test_extend();
      test_sh_delayed();
      test_alu();
      test_spurious_ack();
      test_reset_mid_access();
`ifndef MEM_MISALIGN_ERR_EN
      test_wrap();
`else
      test_misalign();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
